// File: rtl/mmio_perf_counters.sv
// MMIO performance counters: cycle, retired-instruction, branch and correct-branch counts.
// Read back with one-cycle latency; a store to the reset offset clears all four counters.
module mmio_perf_counters #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_retire,
    input  logic        br_retire,
    input  logic        br_correct,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [3:0]  wr_mask,
    input  logic        rd_en,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_hit
);

    localparam logic [31:0] AddrCycle   = BASE_ADDR + 32'h10;
    localparam logic [31:0] AddrInstr   = BASE_ADDR + 32'h14;
    localparam logic [31:0] AddrReset   = BASE_ADDR + 32'h18;
    localparam logic [31:0] AddrBranch  = BASE_ADDR + 32'h1c;
    localparam logic [31:0] AddrCorrect = BASE_ADDR + 32'h20;

    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cycle_q, instr_q, branch_q, correct_q;
    logic                 clr;
    logic                 br_valid;
    logic [31:0]          rd_val;
    logic                 rd_map;

    assign clr      = wr_en && (wr_addr == AddrReset) && (wr_mask != 4'h0);
    assign br_valid = inst_retire && br_retire;

    // Full-address compare, so misaligned and out-of-region addresses fall to default.
    always_comb begin
        rd_val = 32'h0;
        rd_map = 1'b0;
        case (rd_addr)
            AddrCycle: begin
                rd_val = 32'(cycle_q);
                rd_map = 1'b1;
            end
            AddrInstr: begin
                rd_val = 32'(instr_q);
                rd_map = 1'b1;
            end
            AddrBranch: begin
                rd_val = 32'(branch_q);
                rd_map = 1'b1;
            end
            AddrCorrect: begin
                rd_val = 32'(correct_q);
                rd_map = 1'b1;
            end
            default: begin
                rd_val = 32'h0;
                rd_map = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            instr_q   <= '0;
            branch_q  <= '0;
            correct_q <= '0;
            rd_data   <= 32'h0;
            rd_hit    <= 1'b0;
        end else begin
            if (clr) begin
                cycle_q   <= '0;
                instr_q   <= '0;
                branch_q  <= '0;
                correct_q <= '0;
            end else begin
                cycle_q <= cycle_q + CntOne;
                if (inst_retire) instr_q <= instr_q + CntOne;
                if (br_valid) branch_q <= branch_q + CntOne;
                if (br_valid && br_correct) correct_q <= correct_q + CntOne;
            end
            // Read samples the pre-update values; holds across stalls when rd_en is low.
            if (rd_en) begin
                rd_data <= rd_val;
                rd_hit  <= rd_map;
            end
        end
    end

endmodule

// File: doc/mmio_perf_counters.md
Name: mmio_perf_counters

Overview:
- Memory-mapped performance-counter block on the CPU's MMIO bus (0x8000_0000 region).
- Counts cycles, retired instructions, retired branches and correctly predicted branches, using events from the pipeline writeback stage.
- Serves LW reads from the memory stage and clears all counters on a store to the reset address.
- Feeds the load-result mux alongside DMem, with DMem-like one-cycle read latency.

Parameters:
- CNT_WIDTH, 32, counter width; counters wrap modulo 2^CNT_WIDTH; rd_data is zero-extended to 32.
- BASE_ADDR, 32'h8000_0000, MMIO region base. Offsets: 0x10 cycle, 0x14 instruction, 0x18 reset (write-only), 0x1c branch, 0x20 correct-branch.

Ports:
- clk  in  1  CPU clock
- rst  in  1  synchronous, active-high reset
- inst_retire  in  1  one valid (non-bubble, non-flushed) instruction retires this cycle
- br_retire  in  1  retiring instruction is a conditional branch
- br_correct  in  1  retiring branch was predicted correctly; ignored unless br_retire=1
- wr_en  in  1  store issued to the MMIO bus this cycle
- wr_addr  in  32  store byte address
- wr_mask  in  4  store byte enables
- rd_en  in  1  load issued to the MMIO bus this cycle
- rd_addr  in  32  load byte address
- rd_data  out  32  load result, valid the cycle after rd_en
- rd_hit  out  1  registered; 1 when the previous cycle's rd_addr decoded to a counter offset

Behaviour:
- Reset: on the rst edge all four counters, rd_data and rd_hit go to 0. While rst is held, nothing counts.
- Cycle counter: +1 on every clk edge with rst=0 and no counter-reset store. The first post-reset edge takes it 0 to 1.
- Instruction counter: +1 on each edge with inst_retire=1.
- Branch counter: +1 on each edge with inst_retire=1 and br_retire=1.
- Correct-branch counter: +1 on each edge with inst_retire=1, br_retire=1 and br_correct=1.
- Branch event validity: br_retire or br_correct with inst_retire=0 is ignored.
- Invariant: correct-branch ≤ branch ≤ instruction.
- Counter-reset store:
  - Fires when wr_en=1, wr_addr==BASE_ADDR+0x18 and wr_mask!=0.
  - On that edge all four counters load 0 and take no increment, even if events are present the same cycle. Counter reset takes precedence over increments.
  - The store itself is not counted as an instruction (its retire pulse coincides with or precedes this edge).
  - Store data is ignored.
- Other stores: stores to 0x10/0x14/0x1c/0x20 or unmapped addresses have no effect. Counters are read-only.
- Reads:
  - Address decode uses the full 32-bit address: BASE_ADDR + offset, word aligned.
  - rd_addr[1:0]!=0 is treated as unmapped.
  - On an edge with rd_en=1, rd_data and rd_hit are registered from the counter values before that edge's update (pre-increment, pre-clear).
  - Reading 0x18 or any unmapped address gives rd_data=0, rd_hit=0.
  - With rd_en=0, rd_data and rd_hit hold their previous values (pipeline-stall safe).
- Simultaneous read and clear in the same cycle: the read returns the old value; the counters become 0.
- Wrap-around: a counter at 2^CNT_WIDTH−1 wraps to 0 with no flag.
- Reset mid-operation: rst overrides any pending read or store in that cycle. Outputs and counters are 0 on the next cycle.
- Latency:
  - Read: 1 cycle.
  - Counter update: visible to a read issued one cycle after the event.

Test Plan:
- Cycle count after clear: rst for 10 cycles, then clear store; 5 idle cycles; read 0x10 → rd_data=5, rd_hit=1.
- Instruction count: clear, then 10 cycles of inst_retire=1; read 0x14 → 10; branch (0x1c) and correct-branch (0x20) both read 0.
- Loop branches: clear, then 9 retire events with br_retire=1, br_correct=1 on 6 of them and br_correct=1 with br_retire=0 on 2 further cycles; read 0x1c → 9, 0x20 → 6.
- Clear precedence: counters at 7, then clear store on the same edge as inst_retire=1 with rd_en on 0x14; rd_data=7 next cycle, and a subsequent read of 0x14 → 0.
- Wrap and unmapped: force the instruction counter to 32'hFFFF_FFFF, one retire → read 0x14 = 0. Read 0x24 → rd_data=0, rd_hit=0. Read 0x18 → 0. Store to 0x10 leaves the cycle count unaffected.
- Hold and rst: read 0x10, then rd_en=0 for 3 cycles → rd_data unchanged. Assert rst mid-stream → rd_data=0, rd_hit=0, all counters 0.
